vga_pmod_out: RTL and testbench

- Output stage directly downstream of the VGA text/glyph renderer.
- Consumes the renderer's registered active-low hsync/vsync and its 1-bit pixel.
- Re-aligns the pixel to the syncs and colourises it with a slowly cycling RGB222 palette.
- Monitors sync timing for lock and drives the TinyVGA PMOD byte.

---
 rtl/vga_pmod_pkg.sv | 53 +++++
 rtl/vga_pmod_if.sv | 14 +
 rtl/vga_pmod_sync_lock_monitor.sv | 72 +++++++
 rtl/vga_pmod_out.sv | 78 +++++++
 tb/tb_vga_pmod_out.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pmod_pkg.sv
// Shared types, palette and TinyVGA bit map for the VGA PMOD output stage.
package vga_pmod_pkg;

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} lock_state_t;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb222_t;

  // Hue wheel: red, yellow, green, cyan, blue, magenta
  localparam rgb222_t PALETTE [6] = '{
    '{2'd3, 2'd0, 2'd0},
    '{2'd3, 2'd3, 2'd0},
    '{2'd0, 2'd3, 2'd0},
    '{2'd0, 2'd3, 2'd3},
    '{2'd0, 2'd0, 2'd3},
    '{2'd3, 2'd0, 2'd3}
  };

  localparam int UO_HS = 7;
  localparam int UO_B0 = 6;
  localparam int UO_G0 = 5;
  localparam int UO_R0 = 4;
  localparam int UO_VS = 3;
  localparam int UO_B1 = 2;
  localparam int UO_G1 = 1;
  localparam int UO_R1 = 0;

  function automatic rgb222_t halve(rgb222_t c);
    rgb222_t h;
    h.r = c.r >> 1;
    h.g = c.g >> 1;
    h.b = c.b >> 1;
    return h;
  endfunction

  function automatic logic [7:0] pack_uo(logic hs, logic vs, rgb222_t c);
    logic [7:0] u;
    u        = '0;
    u[UO_HS] = hs;
    u[UO_B0] = c.b[0];
    u[UO_G0] = c.g[0];
    u[UO_R0] = c.r[0];
    u[UO_VS] = vs;
    u[UO_B1] = c.b[1];
    u[UO_G1] = c.g[1];
    u[UO_R1] = c.r[1];
    return u;
  endfunction

endpackage

// File: rtl/vga_pmod_if.sv
// Renderer-to-PMOD bus: syncs and pixel in, TinyVGA byte and status out.
interface vga_pmod_if;
  logic       hsync_in;
  logic       vsync_in;
  logic       pix_in;
  logic [7:0] uo_out;
  logic       frame_tick;
  logic       locked;

  modport master (output hsync_in, vsync_in, pix_in,
                  input  uo_out, frame_tick, locked);
  modport slave  (input  hsync_in, vsync_in, pix_in,
                  output uo_out, frame_tick, locked);
endinterface

// File: rtl/vga_pmod_sync_lock_monitor.sv
// Sync edge detect, line/frame counters and lock FSM. With VGA_SCANLINE_EN
// the line-counter parity is exported for scanline dimming.
module sync_lock_monitor
  import vga_pmod_pkg::*;
#(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic clk,
  input  logic rst,
  input  logic hsync,
  input  logic vsync,
  output logic vs_fall,
  output logic frame_tick,
`ifdef VGA_SCANLINE_EN
  output logic line_odd,
`endif
  output logic locked
);

  logic        hs_prev, vs_prev, hs_fall;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic        h_ok, v_ok;
  lock_state_t state;

  assign hs_fall = hs_prev & ~hsync;
  assign vs_fall = vs_prev & ~vsync;
  assign h_ok    = (hcnt == 11'(H_TOTAL - 1));
  assign v_ok    = (vcnt == 10'(V_TOTAL));
`ifdef VGA_SCANLINE_EN
  assign line_odd = vcnt[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_prev    <= 1'b1;
      vs_prev    <= 1'b1;
      hcnt       <= '0;
      vcnt       <= '0;
      state      <= SEARCH;
      locked     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      hs_prev    <= hsync;
      vs_prev    <= vsync;
      frame_tick <= vs_fall;

      if (hs_fall)               hcnt <= '0;
      else if (hcnt != 11'h7FF)  hcnt <= hcnt + 11'd1;

      // A line that starts on the same clock as the frame counts as line 1
      if (vs_fall)                        vcnt <= {9'd0, hs_fall};
      else if (hs_fall && vcnt != 10'h3FF) vcnt <= vcnt + 10'd1;

      // locked tracks the next state so it moves on the clock after the edge
      case (state)
        SEARCH: if (vs_fall) state <= CHECK;
        default: begin
          if ((hs_fall && !h_ok) || (vs_fall && !v_ok)) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end else if (vs_fall) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/vga_pmod_out.sv
// VGA PMOD output stage: pixel realign, hue cycling palette, TinyVGA byte.
// Optional VGA_SCANLINE_EN halves colour on odd counted lines.
module vga_pmod_out
  import vga_pmod_pkg::*;
#(
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter int PIX_DELAY    = 1,
  parameter int CYCLE_FRAMES = 60
) (
  input logic       clk,
  input logic       rst,
  vga_pmod_if.slave bus
);

  localparam int FC_W = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;

  logic            vs_fall, pix_d;
  logic [2:0]      hue;
  logic [FC_W-1:0] fcnt;
  rgb222_t         colour;
`ifdef VGA_SCANLINE_EN
  logic            line_odd;
`endif

  sync_lock_monitor #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)) u_mon (
    .clk        (clk),
    .rst        (rst),
    .hsync      (bus.hsync_in),
    .vsync      (bus.vsync_in),
    .vs_fall    (vs_fall),
    .frame_tick (bus.frame_tick),
`ifdef VGA_SCANLINE_EN
    .line_odd   (line_odd),
`endif
    .locked     (bus.locked)
  );

  // Renderer pixel leads its registered syncs; delay it back into line
  if (PIX_DELAY == 0) begin : g_nodly
    assign pix_d = bus.pix_in;
  end else begin : g_dly
    logic [PIX_DELAY-1:0] sr;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sr <= '0;
      else     sr <= (sr << 1) | PIX_DELAY'(bus.pix_in);
    end
    assign pix_d = sr[PIX_DELAY-1];
  end

  always_comb begin
    colour = '0;
    if (pix_d && bus.locked) colour = PALETTE[hue];
`ifdef VGA_SCANLINE_EN
    if (line_odd) colour = halve(colour);
`endif
  end

  // Hue only advances on frames seen while locked; lock loss just freezes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hue        <= 3'd0;
      fcnt       <= '0;
      bus.uo_out <= 8'h88;
    end else begin
      if (vs_fall && bus.locked) begin
        if (fcnt == FC_W'(CYCLE_FRAMES - 1)) begin
          fcnt <= '0;
          hue  <= (hue == 3'd5) ? 3'd0 : hue + 3'd1;
        end else begin
          fcnt <= fcnt + FC_W'(1);
        end
      end
      bus.uo_out <= pack_uo(bus.hsync_in, bus.vsync_in, colour);
    end
  end

endmodule

// File: tb/tb_vga_pmod_out.sv
// Randomized-pixel bench for vga_pmod_out on a shrunk 20x12 raster.
module tb_vga_pmod_out;
  localparam int HT = 20, VT = 12, PD = 1, CF = 2;
  localparam int HS_S = 14, HS_E = 17, VS_S = 9, VS_E = 11, ACT_W = 12, ACT_H = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  vga_pmod_if bus();

  vga_pmod_out #(.H_TOTAL(HT), .V_TOTAL(VT), .PIX_DELAY(PD), .CYCLE_FRAMES(CF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_run = 0, n_fail = 0;

  // reference model state
  int cyc, good_vs, hue, fcnt, last_hs_t, last_vs_t;
  int hs_times[$];
  bit pix_hist[$];
  bit m_prev_hs, m_prev_vs, m_locked;
  logic [7:0] exp_uo;
  bit exp_lock, exp_tick;
  int gx, gy;

  int pal_r [6] = '{3, 3, 0, 0, 0, 3};
  int pal_g [6] = '{0, 3, 3, 3, 0, 0};
  int pal_b [6] = '{0, 0, 0, 3, 3, 3};
  logic [7:0] hue_byte [6] = '{8'h99, 8'hBB, 8'hAA, 8'hEE, 8'hCC, 8'hDD};

  function void model_reset();
    cyc = 0; good_vs = 0; hue = 0; fcnt = 0; last_hs_t = 0; last_vs_t = 0;
    hs_times.delete();
    pix_hist.delete();
    for (int i = 0; i < PD; i++) pix_hist.push_back(1'b0);
    m_prev_hs = 1'b1; m_prev_vs = 1'b1; m_locked = 1'b0;
    exp_uo = 8'h88; exp_lock = 1'b0; exp_tick = 1'b0;
  endfunction

  // One clock edge of the reference: line length = time between hsync falls,
  // frame length = hsync falls since the previous vsync fall.
  function void model_step(bit hs, bit vs, bit pix);
    bit hf, vf, pd, bad;
    int lines, r, g, b;
    cyc++;
    hf = m_prev_hs && !hs;
    vf = m_prev_vs && !vs;
    pix_hist.push_back(pix);
    pd = pix_hist.pop_front();
    lines = 0;
    foreach (hs_times[i]) if (hs_times[i] >= last_vs_t) lines++;
    if (lines > 1023) lines = 1023;
    r = 0; g = 0; b = 0;
    if (pd && m_locked) begin r = pal_r[hue]; g = pal_g[hue]; b = pal_b[hue]; end
`ifdef VGA_SCANLINE_EN
    if (lines % 2 == 1) begin r = r / 2; g = g / 2; b = b / 2; end
`endif
    exp_uo   = {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
    exp_tick = vf;
    if (vf && m_locked) begin
      fcnt++;
      if (fcnt == CF) begin fcnt = 0; hue = (hue + 1) % 6; end
    end
    bad = (hf && (cyc - last_hs_t != HT)) || (vf && lines != VT);
    if (good_vs == 0) begin
      if (vf) good_vs = 1;
    end else if (bad) good_vs = 0;
    else if (vf && good_vs < 2) good_vs++;
    m_locked = (good_vs >= 2);
    exp_lock = m_locked;
    if (hf) begin hs_times.push_back(cyc); last_hs_t = cyc; end
    if (vf) begin
      last_vs_t = cyc;
      while (hs_times.size() > 0 && hs_times[0] < cyc) void'(hs_times.pop_front());
    end
    m_prev_hs = hs; m_prev_vs = vs;
  endfunction

  task automatic drive(input bit hs, input bit vs, input bit pix);
    bus.hsync_in = hs; bus.vsync_in = vs; bus.pix_in = pix;
    @(posedge clk);
    model_step(hs, vs, pix);
    #1;
  endtask

  // pm < 0: random pixel in the active area, otherwise the forced value
  task automatic gen(input int pm, input bit shorten);
    bit hs, vs, px;
    hs = !(gx >= HS_S && gx < HS_E);
    vs = !(gy >= VS_S && gy < VS_E);
    px = 1'b0;
    if (gx < ACT_W && gy < ACT_H) px = (pm < 0) ? bit'($urandom_range(1, 0)) : bit'(pm);
    drive(hs, vs, px);
    gx++;
    if (gx >= (shorten ? HT - 1 : HT)) begin gx = 0; gy = (gy == VT - 1) ? 0 : gy + 1; end
  endtask

  task automatic test_reset();
    bus.hsync_in = 1'b1; bus.vsync_in = 1'b1; bus.pix_in = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_run++;
    if ({bus.uo_out, bus.locked, bus.frame_tick} !== {8'h88, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_init: uo=%h lk=%b ft=%b, expected 88/0/0", bus.uo_out, bus.locked, bus.frame_tick);
    end
    rst = 1'b0; gx = 0; gy = 0;
    for (int i = 0; i < 2 * HT * VT + 50; i++) begin
      gen(-1, 1'b0);
      n_run++;
      if ({bus.uo_out, bus.locked, bus.frame_tick} !== {exp_uo, exp_lock, exp_tick}) begin
        n_fail++;
        $display("FAIL reset_prerun: uo=%h lk=%b ft=%b, expected %h/%b/%b", bus.uo_out, bus.locked, bus.frame_tick, exp_uo, exp_lock, exp_tick);
      end
    end
    n_run++;
    if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL reset_prelock: locked=%b, expected 1", bus.locked); end
    #3 rst = 1'b1;
    model_reset();
    #1;
    n_run++;
    if ({bus.uo_out, bus.locked, bus.frame_tick} !== {8'h88, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: uo=%h lk=%b ft=%b, expected 88/0/0", bus.uo_out, bus.locked, bus.frame_tick);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      n_run++;
      if ({bus.uo_out, bus.locked, bus.frame_tick} !== {8'h88, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_idle: uo=%h lk=%b ft=%b, expected 88/0/0", bus.uo_out, bus.locked, bus.frame_tick);
      end
    end
    gx = 0; gy = 0;
  endtask

  task automatic test_lock();
    int nvs = 0, ticks = 0;
    bit vedge;
    for (int i = 0; i < 3 * HT * VT; i++) begin
      vedge = (gy == VS_S && gx == 0);
      gen(-1, 1'b0);
      ticks += int'(bus.frame_tick);
      n_run++;
      if ({bus.uo_out, bus.locked, bus.frame_tick} !== {exp_uo, exp_lock, exp_tick}) begin
        n_fail++;
        $display("FAIL lock_seq: uo=%h lk=%b ft=%b, expected %h/%b/%b", bus.uo_out, bus.locked, bus.frame_tick, exp_uo, exp_lock, exp_tick);
      end
      if (vedge) begin
        nvs++;
        n_run++;
        if (bus.locked !== (nvs >= 2)) begin
          n_fail++;
          $display("FAIL lock_edge%0d: locked=%b, expected %b", nvs, bus.locked, nvs >= 2);
        end
      end
    end
    n_run++;
    if (ticks != 3) begin n_fail++; $display("FAIL lock_ticks: got %0d frame ticks, expected 3", ticks); end
  endtask

  task automatic test_pixel();
    int px, py;
    logic [7:0] want;
    for (int i = 0; i < HT * VT; i++) begin
      px = gx; py = gy;
      gen((py == 1 || py == 2) ? int'(px == 3) : -1, 1'b0);
      n_run++;
      if ({bus.uo_out, bus.locked, bus.frame_tick} !== {exp_uo, exp_lock, exp_tick}) begin
        n_fail++;
        $display("FAIL pixel_seq: uo=%h lk=%b ft=%b, expected %h/%b/%b", bus.uo_out, bus.locked, bus.frame_tick, exp_uo, exp_lock, exp_tick);
      end
      if ((py == 1 || py == 2) && px < HS_S) begin
        want = 8'h88;
`ifdef VGA_SCANLINE_EN
        if (px - PD == 3) want = (py == 2) ? 8'h98 : 8'h99;
`else
        if (px - PD == 3) want = 8'h99;
`endif
        n_run++;
        if (bus.uo_out !== want) begin
          n_fail++;
          $display("FAIL pixel_latency line%0d x%0d: uo=%h, expected %h", py, px, bus.uo_out, want);
        end
      end
    end
  endtask

  task automatic test_hue_cycle();
    int px, py;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0; gx = 0; gy = 0;
    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < HT * VT; i++) begin
        px = gx; py = gy;
        gen((py == 1 && px == 5) ? 1 : -1, 1'b0);
        n_run++;
        if ({bus.uo_out, bus.locked, bus.frame_tick} !== {exp_uo, exp_lock, exp_tick}) begin
          n_fail++;
          $display("FAIL hue_seq: uo=%h lk=%b ft=%b, expected %h/%b/%b", bus.uo_out, bus.locked, bus.frame_tick, exp_uo, exp_lock, exp_tick);
        end
        if (f >= 2 && py == 1 && px == 5 + PD) begin
          n_run++;
          if (bus.uo_out !== hue_byte[((f - 2) / 2) % 6]) begin
            n_fail++;
            $display("FAIL hue_frame%0d: uo=%h, expected %h", f - 2, bus.uo_out, hue_byte[((f - 2) / 2) % 6]);
          end
        end
      end
    end
  endtask

  task automatic test_glitch();
    int px, py;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < HT * VT - ((f == 0) ? 1 : 0); i++) begin
        px = gx; py = gy;
        gen((py == 1 && px == 5) ? 1 : -1, (f == 0 && gy == 4));
        n_run++;
        if ({bus.uo_out, bus.locked, bus.frame_tick} !== {exp_uo, exp_lock, exp_tick}) begin
          n_fail++;
          $display("FAIL glitch_seq: uo=%h lk=%b ft=%b, expected %h/%b/%b", bus.uo_out, bus.locked, bus.frame_tick, exp_uo, exp_lock, exp_tick);
        end
        if (f == 0 && py == 5 && (px == HS_S - 1 || px == HS_S)) begin
          n_run++;
          if (bus.locked !== (px == HS_S - 1)) begin
            n_fail++;
            $display("FAIL glitch_drop x%0d: locked=%b, expected %b", px, bus.locked, px == HS_S - 1);
          end
        end
        if (f == 1 && ((py == VS_S - 1 && px == 0) || (py == VS_S && px == 0))) begin
          n_run++;
          if (bus.locked !== (py == VS_S)) begin
            n_fail++;
            $display("FAIL glitch_relock line%0d: locked=%b, expected %b", py, bus.locked, py == VS_S);
          end
        end
        if (f >= 1 && py == 1 && px == 5 + PD) begin
          n_run++;
          if (bus.uo_out !== ((f == 1) ? 8'h88 : 8'hBB)) begin
            n_fail++;
            $display("FAIL glitch_colour f%0d: uo=%h, expected %h", f, bus.uo_out, (f == 1) ? 8'h88 : 8'hBB);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pixel();
    test_hue_cycle();
    test_glitch();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
